// File: rtl/dbg_loader_pkg.sv
// Shared definitions for dbg_loader: command opcodes, status codes and the
// FSM state encoding. The CSUM state only exists when DBG_LOADER_CHECKSUM_EN
// is defined.
package dbg_loader_pkg;

  // Command opcodes (first byte of every command)
  localparam logic [7:0] CMD_WR_IMEM = 8'h01;
  localparam logic [7:0] CMD_RD_REG  = 8'h02;
  localparam logic [7:0] CMD_RD_DMEM = 8'h03;
  localparam logic [7:0] CMD_RUN     = 8'h04;
  localparam logic [7:0] CMD_HALT    = 8'h05;

  // Status bytes
  localparam logic [7:0] ST_OK       = 8'hA5;
  localparam logic [7:0] ST_UNKNOWN  = 8'hEE;
  localparam logic [7:0] ST_RUNNING  = 8'hE1;
  localparam logic [7:0] ST_CSUM_ERR = 8'hE2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARG,
    S_DATA,
    S_READ,
    S_CAPT,
    S_EXEC,
    S_RESP
`ifdef DBG_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

endpackage

// File: rtl/dbg_loader_if.sv
// Byte-stream command/response channel between a host (master) and the
// dbg_loader (slave). Both directions use a valid/ready handshake.
interface dbg_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dbg_loader.sv
// dbg_loader: byte-serial debug and program-load port for the RISC-V core.
// Writes IMEM words, reads register-file / DMEM words, and controls the core
// hold and PC-clear lines from a simple command stream.
// Optional feature: define DBG_LOADER_CHECKSUM_EN to append an XOR checksum
// byte to WR_IMEM (mismatch -> no write, status 0xE2).
module dbg_loader
  import dbg_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  dbg_loader_if.slave       bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [4:0]        rf_raddr,
  input  logic [31:0]       rf_rdata,
  output logic [ADDR_W-1:0] dmem_raddr,
  input  logic [31:0]       dmem_rdata,
  output logic              core_hold,
  output logic              pc_clear
);

  state_t              r_state, w_state_next;
  logic [7:0]          r_cmd;
  logic [7:0]          r_status;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_shift;
  logic [1:0]          r_cnt;
  logic [1:0]          r_resp_cnt;
  logic                r_in_ready, r_out_valid;
  logic [7:0]          r_out_data;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr, r_dmem_raddr;
  logic [31:0]         r_imem_wdata;
  logic [4:0]          r_rf_raddr;
  logic                r_hold, r_pc_clear;
`ifdef DBG_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  logic        w_in_fire, w_out_fire, w_ready_next;
  logic [31:0] w_rd_word;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign w_rd_word  = (r_cmd == CMD_RD_REG) ? rf_rdata : dmem_rdata;

  // in_ready is registered from the next state so it is low during reset
  // and rises on the first clock after RST_N deasserts.
  assign w_ready_next = (w_state_next == S_IDLE) || (w_state_next == S_ARG) ||
`ifdef DBG_LOADER_CHECKSUM_EN
                        (w_state_next == S_CSUM) ||
`endif
                        (w_state_next == S_DATA);

  // State register
  always_ff @(posedge CLK) begin
    // NOTE: sequential state always uses non-blocking (<=) assignments so every
    // register samples the pre-edge values of its sources.
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch forms.
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_in_fire) begin
        case (bus.in_data)
          CMD_WR_IMEM, CMD_RD_REG, CMD_RD_DMEM: w_state_next = S_ARG;
          CMD_RUN, CMD_HALT:                    w_state_next = S_EXEC;
          default:                              w_state_next = S_RESP;
        endcase
      end
      S_ARG:  if (w_in_fire) w_state_next = (r_cmd == CMD_WR_IMEM) ? S_DATA : S_READ;
`ifdef DBG_LOADER_CHECKSUM_EN
      S_DATA: if (w_in_fire && r_cnt == 2'd3) w_state_next = S_CSUM;
      S_CSUM: if (w_in_fire) w_state_next = S_EXEC;
`else
      S_DATA: if (w_in_fire && r_cnt == 2'd3) w_state_next = S_EXEC;
`endif
      S_READ: w_state_next = S_CAPT;
      S_CAPT: w_state_next = S_RESP;
      S_EXEC: w_state_next = S_RESP;
      S_RESP: if (w_out_fire && r_resp_cnt == 2'd0) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, IMEM write, read capture, core control, response
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cmd        <= '0;
      r_status     <= '0;
      r_addr       <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_resp_cnt   <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_rf_raddr   <= '0;
      r_dmem_raddr <= '0;
      r_hold       <= 1'b1;
      r_pc_clear   <= 1'b0;
`ifdef DBG_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_in_ready  <= w_ready_next;
      r_out_valid <= (w_state_next == S_RESP);
      r_imem_we   <= 1'b0;
      r_pc_clear  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_in_fire) begin
          r_cmd    <= bus.in_data;
          r_status <= ST_OK;
          case (bus.in_data)
            CMD_WR_IMEM, CMD_RD_REG, CMD_RD_DMEM: ;
            CMD_RUN: begin
              r_hold     <= 1'b0;
              r_pc_clear <= 1'b1;
            end
            CMD_HALT: r_hold <= 1'b1;
            default: begin
              r_out_data <= ST_UNKNOWN;
              r_resp_cnt <= 2'd0;
            end
          endcase
        end
        S_ARG: if (w_in_fire) begin
          if (r_cmd == CMD_WR_IMEM) begin
            r_addr <= bus.in_data[ADDR_W-1:0];
            r_cnt  <= 2'd0;
`ifdef DBG_LOADER_CHECKSUM_EN
            r_csum <= 8'h00;
`endif
          end else if (r_cmd == CMD_RD_REG) begin
            r_rf_raddr <= bus.in_data[4:0];
          end else begin
            r_dmem_raddr <= bus.in_data[ADDR_W-1:0];
          end
        end
        S_DATA: if (w_in_fire) begin
          r_shift <= {bus.in_data, r_shift[31:8]};
          r_cnt   <= r_cnt + 2'd1;
`ifdef DBG_LOADER_CHECKSUM_EN
          r_csum  <= r_csum ^ bus.in_data;
`else
          if (r_cnt == 2'd3) begin
            // A running core never sees its IMEM modified.
            r_imem_we <= r_hold;
            r_status  <= r_hold ? ST_OK : ST_RUNNING;
            if (r_hold) begin
              r_imem_addr  <= r_addr;
              r_imem_wdata <= {bus.in_data, r_shift[31:8]};
            end
          end
`endif
        end
`ifdef DBG_LOADER_CHECKSUM_EN
        S_CSUM: if (w_in_fire) begin
          if (!r_hold) begin
            r_status <= ST_RUNNING;
          end else if (bus.in_data != r_csum) begin
            r_status <= ST_CSUM_ERR;
          end else begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_addr;
            r_imem_wdata <= r_shift;
            r_status     <= ST_OK;
          end
        end
`endif
        S_CAPT: begin
          r_out_data <= w_rd_word[7:0];
          r_shift    <= {8'h00, w_rd_word[31:8]};
          r_resp_cnt <= 2'd3;
        end
        S_EXEC: begin
          r_out_data <= r_status;
          r_resp_cnt <= 2'd0;
        end
        S_RESP: if (w_out_fire && r_resp_cnt != 2'd0) begin
          r_out_data <= r_shift[7:0];
          r_shift    <= {8'h00, r_shift[31:8]};
          r_resp_cnt <= r_resp_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign imem_we       = r_imem_we;
  assign imem_addr     = r_imem_addr;
  assign imem_wdata    = r_imem_wdata;
  assign rf_raddr      = r_rf_raddr;
  assign dmem_raddr    = r_dmem_raddr;
  assign core_hold     = r_hold;
  assign pc_clear      = r_pc_clear;

endmodule

// File: tb/tb_dbg_loader.sv
// Directed testbench for dbg_loader. Inputs are driven on the falling edge or
// 1 ns after the rising edge; outputs are sampled away from the rising edge.
module tb_dbg_loader;
  import dbg_loader_pkg::*;

  logic        clk, rst_n;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [7:0]  dmem_raddr;
  logic [31:0] dmem_rdata;
  logic        core_hold, pc_clear;

  int n_cmp = 0;
  int n_bad = 0;

  dbg_loader_if u_if ();

  dbg_loader #(.ADDR_W(8)) u_dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .bus        (u_if.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .dmem_raddr (dmem_raddr),
    .dmem_rdata (dmem_rdata),
    .core_hold  (core_hold),
    .pc_clear   (pc_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file / DMEM models with one cycle of read latency
  initial begin
    rf_rdata   = 32'h0;
    dmem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    rf_rdata   <= (rf_raddr == 5'd5) ? 32'h0000_0003 : (32'h5A5A_0000 | {27'h0, rf_raddr});
    dmem_rdata <= 32'hCAFE_0000 | {24'h0, dmem_raddr};
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1);
  end

  // Offer one byte and return 1 ns after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.in_data  = b;
    while (u_if.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready got %b want 1", u_if.in_ready);
    end
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
  endtask

  // Wait for a response byte, take it, return 1 ns after the consuming edge.
  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    while (u_if.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL recv_timeout: out_valid got %b want 1", u_if.out_valid);
    end
    b = u_if.out_data;
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
  endtask

  task automatic send_wr(input logic [7:0] addr, input logic [31:0] word);
    logic [7:0] cs;
    cs = word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
    send_byte(CMD_WR_IMEM);
    send_byte(addr);
    for (int i = 0; i < 4; i++) send_byte(word[8*i +: 8]);
`ifdef DBG_LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    if (cs === 8'hxx) $display("note: checksum undefined");
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_data = 8'h00; u_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (u_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", u_if.in_ready); end
    n_cmp++; if (u_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", u_if.out_valid); end
    n_cmp++; if (u_if.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %h want 00", u_if.out_data); end
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL rst_imem_we: got %b want 0", imem_we); end
    n_cmp++; if (imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_imem_bus: got %h/%h want 00/00000000", imem_addr, imem_wdata); end
    n_cmp++; if (rf_raddr !== 5'd0 || dmem_raddr !== 8'h00) begin n_bad++; $display("FAIL rst_raddr: got %h/%h want 00/00", rf_raddr, dmem_raddr); end
    n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL rst_core_hold: got %b want 1", core_hold); end
    n_cmp++; if (pc_clear !== 1'b0) begin n_bad++; $display("FAIL rst_pc_clear: got %b want 0", pc_clear); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (u_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %b want 1", u_if.in_ready); end
  endtask

  task automatic test_run();
    logic [7:0] b;
    send_byte(CMD_RUN);
    n_cmp++; if (core_hold !== 1'b0) begin n_bad++; $display("FAIL run_hold: got %b want 0", core_hold); end
    n_cmp++; if (pc_clear !== 1'b1) begin n_bad++; $display("FAIL run_pc_clear: got %b want 1", pc_clear); end
    n_cmp++; if (u_if.out_valid !== 1'b0 || u_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL run_exec_hs: got ov=%b ir=%b want 0/0", u_if.out_valid, u_if.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (pc_clear !== 1'b0) begin n_bad++; $display("FAIL run_pc_clear_end: got %b want 0", pc_clear); end
    n_cmp++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== ST_OK) begin n_bad++; $display("FAIL run_status_timing: got ov=%b %h want 1 a5", u_if.out_valid, u_if.out_data); end
    recv_byte(b);
    n_cmp++; if (b !== ST_OK) begin n_bad++; $display("FAIL run_status: got %h want a5", b); end
    n_cmp++; if (u_if.out_valid !== 1'b0 || u_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL run_back_idle: got ov=%b ir=%b want 0/1", u_if.out_valid, u_if.in_ready); end
  endtask

  task automatic test_wr_running();
    logic [7:0] b;
    send_wr(8'h04, 32'h4433_2211);
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL wrrun_we: got %b want 0", imem_we); end
    @(posedge clk); #1;
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL wrrun_we_late: got %b want 0", imem_we); end
    recv_byte(b);
    n_cmp++; if (b !== ST_RUNNING) begin n_bad++; $display("FAIL wrrun_status: got %h want e1", b); end
    send_byte(CMD_HALT);
    n_cmp++; if (core_hold !== 1'b1 || pc_clear !== 1'b0) begin n_bad++; $display("FAIL halt_ctrl: got hold=%b pc=%b want 1/0", core_hold, pc_clear); end
    recv_byte(b);
    n_cmp++; if (b !== ST_OK) begin n_bad++; $display("FAIL halt_status: got %h want a5", b); end
    send_byte(CMD_HALT);
    n_cmp++; if (core_hold !== 1'b1 || pc_clear !== 1'b0) begin n_bad++; $display("FAIL halt2_ctrl: got hold=%b pc=%b want 1/0", core_hold, pc_clear); end
    recv_byte(b);
    n_cmp++; if (b !== ST_OK) begin n_bad++; $display("FAIL halt2_status: got %h want a5", b); end
    send_wr(8'h04, 32'h4433_2211);
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 8'h04 || imem_wdata !== 32'h4433_2211) begin n_bad++; $display("FAIL wrretry_write: got we=%b %h %h want 1 04 44332211", imem_we, imem_addr, imem_wdata); end
    recv_byte(b);
    n_cmp++; if (b !== ST_OK) begin n_bad++; $display("FAIL wrretry_status: got %h want a5", b); end
  endtask

  task automatic test_wr_imem();
    logic [7:0] b;
    send_wr(8'h00, 32'h0020_8233);
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h0020_8233) begin n_bad++; $display("FAIL wr0_write: got we=%b %h %h want 1 00 00208233", imem_we, imem_addr, imem_wdata); end
    n_cmp++; if (u_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL wr0_in_ready: got %b want 0", u_if.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL wr0_we_pulse: got %b want 0", imem_we); end
    n_cmp++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== ST_OK) begin n_bad++; $display("FAIL wr0_status_timing: got ov=%b %h want 1 a5", u_if.out_valid, u_if.out_data); end
    recv_byte(b);
    n_cmp++; if (b !== ST_OK) begin n_bad++; $display("FAIL wr0_status: got %h want a5", b); end
    send_wr(8'hFF, 32'h0010_0513);
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 8'hFF || imem_wdata !== 32'h0010_0513) begin n_bad++; $display("FAIL wrff_write: got we=%b %h %h want 1 ff 00100513", imem_we, imem_addr, imem_wdata); end
    recv_byte(b);
    n_cmp++; if (b !== ST_OK) begin n_bad++; $display("FAIL wrff_status: got %h want a5", b); end
  endtask

  task automatic test_rd_reg();
    logic [31:0] exp_word;
    logic [7:0]  exp_b;
    int          stall;
    exp_word = 32'h0000_0003;
    send_byte(CMD_RD_REG);
    send_byte(8'h05);
    n_cmp++; if (rf_raddr !== 5'd5) begin n_bad++; $display("FAIL rdreg_raddr: got %0d want 5", rf_raddr); end
    n_cmp++; if (u_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL rdreg_read_ov: got %b want 0", u_if.out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (u_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL rdreg_capt_ov: got %b want 0", u_if.out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (u_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL rdreg_latency: got ov=%b want 1", u_if.out_valid); end
    for (int i = 0; i < 4; i++) begin
      exp_b = exp_word[8*i +: 8];
      stall = $urandom_range(1, 3);
      for (int k = 0; k < stall; k++) begin
        n_cmp++;
        if (u_if.out_valid !== 1'b1 || u_if.out_data !== exp_b) begin
          n_bad++;
          $display("FAIL rdreg_byte%0d_hold: got ov=%b %h want 1 %h", i, u_if.out_valid, u_if.out_data, exp_b);
        end
        @(posedge clk); #1;
      end
      u_if.out_ready = 1'b1;
      @(posedge clk); #1;
      u_if.out_ready = 1'b0;
    end
    n_cmp++; if (u_if.out_valid !== 1'b0 || u_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL rdreg_done: got ov=%b ir=%b want 0/1", u_if.out_valid, u_if.in_ready); end
  endtask

  task automatic test_rd_dmem_running();
    logic [7:0]  b;
    logic [31:0] got;
    send_byte(CMD_RUN);
    recv_byte(b);
    send_byte(CMD_RD_DMEM);
    send_byte(8'h07);
    n_cmp++; if (dmem_raddr !== 8'h07) begin n_bad++; $display("FAIL rddm_raddr: got %h want 07", dmem_raddr); end
    for (int i = 0; i < 4; i++) begin
      recv_byte(b);
      got[8*i +: 8] = b;
    end
    n_cmp++; if (got !== 32'hCAFE_0007) begin n_bad++; $display("FAIL rddm_data: got %h want cafe0007", got); end
    n_cmp++; if (core_hold !== 1'b0) begin n_bad++; $display("FAIL rddm_hold: got %b want 0", core_hold); end
    send_byte(CMD_HALT);
    recv_byte(b);
  endtask

  task automatic test_unknown();
    logic [7:0] b;
    send_byte(8'h7F);
    n_cmp++; if (u_if.out_valid !== 1'b1 || u_if.out_data !== ST_UNKNOWN || u_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL unk_resp: got ov=%b %h ir=%b want 1 ee 0", u_if.out_valid, u_if.out_data, u_if.in_ready); end
    recv_byte(b);
    n_cmp++; if (b !== ST_UNKNOWN) begin n_bad++; $display("FAIL unk_status: got %h want ee", b); end
    n_cmp++; if (u_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL unk_idle: got ir=%b want 1", u_if.in_ready); end
  endtask

  task automatic test_run_restart();
    logic [7:0] b;
    send_byte(CMD_RUN);
    recv_byte(b);
    send_byte(CMD_RUN);
    n_cmp++; if (pc_clear !== 1'b1 || core_hold !== 1'b0) begin n_bad++; $display("FAIL restart_ctrl: got pc=%b hold=%b want 1/0", pc_clear, core_hold); end
    recv_byte(b);
    n_cmp++; if (b !== ST_OK) begin n_bad++; $display("FAIL restart_status: got %h want a5", b); end
  endtask

  task automatic test_reset_mid_wr();
    logic [7:0] b;
    send_byte(CMD_WR_IMEM);
    send_byte(8'h10);
    send_byte(8'hAA);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (imem_we !== 1'b0 || core_hold !== 1'b1 || u_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_state: got we=%b hold=%b ir=%b want 0 1 0", imem_we, core_hold, u_if.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    send_wr(8'h10, 32'h0BAD_F00D);
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 8'h10 || imem_wdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL midrst_next_write: got we=%b %h %h want 1 10 0badf00d", imem_we, imem_addr, imem_wdata); end
    recv_byte(b);
    n_cmp++; if (b !== ST_OK) begin n_bad++; $display("FAIL midrst_next_status: got %h want a5", b); end
    send_byte(8'h7F);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (u_if.out_valid !== 1'b0 || u_if.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_drop_resp: got ov=%b %h want 0 00", u_if.out_valid, u_if.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef DBG_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    logic [7:0] b;
    send_byte(CMD_WR_IMEM);
    send_byte(8'h30);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h04);
    send_byte(8'h08);
    send_byte(8'h0E);
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL csum_we: got %b want 0", imem_we); end
    recv_byte(b);
    n_cmp++; if (b !== ST_CSUM_ERR) begin n_bad++; $display("FAIL csum_status: got %h want e2", b); end
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_wr_running();
    test_wr_imem();
    test_rd_reg();
    test_rd_dmem_running();
    test_unknown();
    test_run_restart();
    test_reset_mid_wr();
`ifdef DBG_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
